// File: rtl/anton_neopixel_pixel_serializer_pkg.sv
// Shared constants for the NeoPixel pixel serializer: fetch state encodings,
// default bit timings and the RGB332 to GRB expansion.
package anton_neopixel_pixel_serializer_pkg;

  localparam int BUFFER_END_DEFAULT = 255;
  localparam int T0H_STEPS_DEFAULT  = 2;
  localparam int T1H_STEPS_DEFAULT  = 5;

  localparam logic [1:0] ENUM_FETCH_IDLE = 2'd0;
  localparam logic [1:0] ENUM_FETCH_REQ  = 2'd1;
  localparam logic [1:0] ENUM_FETCH_DATA = 2'd2;
  localparam logic [1:0] ENUM_FETCH_DONE = 2'd3;

  // RRRGGGBB -> {G,R,B}, each channel widened by repeating its top bits.
  function automatic logic [23:0] rgb332_to_grb(input logic [7:0] px);
    return {px[4:2], px[4:2], px[4:3],
            px[7:5], px[7:5], px[7:6],
            px[1:0], px[1:0], px[1:0], px[1:0]};
  endfunction

endpackage

// File: rtl/anton_neopixel_pixel_serializer_if.sv
// Request/grant read port between the serializer and the pixel buffer.
interface anton_neopixel_pixel_serializer_if #(
  parameter int ADDR_BITS = 8
) ();
  logic                 buf_req;
  logic [ADDR_BITS-1:0] buf_addr;
  logic                 buf_gnt;
  logic [7:0]           buf_data;

  modport master (output buf_req, buf_addr, input buf_gnt, buf_data);
  modport slave  (input buf_req, buf_addr, output buf_gnt, buf_data);
endinterface

// File: rtl/anton_neopixel_pixel_fetch.sv
// Prefetches the next pixel into a shadow register over the buffer read port,
// assembling one RGB332 byte or three GRB bytes into 24-bit GRB.
module anton_neopixel_pixel_fetch
  import anton_neopixel_pixel_serializer_pkg::*;
#(
  parameter int BUFFER_BITS = 8
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   stream_output,
  input  logic                   stream_reset,
  input  logic [BUFFER_BITS-1:0] pixel_index,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  input  logic                   reg_ctrl_32bit,
  input  logic                   consume,
  anton_neopixel_pixel_serializer_if.master bus,
  output logic [23:0]            shadow,
  output logic                   shadow_valid
);

  logic [1:0]             state;
  logic [1:0]             beat;
  logic [BUFFER_BITS-1:0] key;
  logic [BUFFER_BITS-1:0] next_index;
  logic [BUFFER_BITS-1:0] target;
  logic                   abort;
  logic                   last_beat;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    key = reg_ctrl_32bit ? (pixel_index | BUFFER_BITS'(3)) : pixel_index;
    if (key == pixel_index_max) next_index = '0;
    else next_index = pixel_index + (reg_ctrl_32bit ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
    target = stream_output ? next_index : pixel_index;
    if (reg_ctrl_32bit) target[1:0] = 2'b00;
  end

  // A load that finds no valid pixel restarts the fetch so it targets the new next pixel.
  assign abort     = (!stream_output && !stream_reset) || (consume && !shadow_valid);
  assign last_beat = !reg_ctrl_32bit || (beat == 2'd2);
  assign bus.buf_req = (state == ENUM_FETCH_REQ);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state        <= ENUM_FETCH_IDLE;
      beat         <= 2'd0;
      bus.buf_addr <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
    end else if (abort) begin
      state        <= ENUM_FETCH_IDLE;
      shadow_valid <= 1'b0;
    end else begin
      if (consume) shadow_valid <= 1'b0;
      case (state)
        ENUM_FETCH_IDLE: begin
          if (!shadow_valid) begin
            state        <= ENUM_FETCH_REQ;
            beat         <= 2'd0;
            bus.buf_addr <= target;
          end
        end
        ENUM_FETCH_REQ: begin
          if (bus.buf_gnt) state <= ENUM_FETCH_DATA;
        end
        ENUM_FETCH_DATA: begin
          if (!reg_ctrl_32bit) begin
            shadow <= rgb332_to_grb(bus.buf_data);
          end else begin
            case (beat)
              2'd0:    shadow[23:16] <= bus.buf_data;
              2'd1:    shadow[15:8]  <= bus.buf_data;
              default: shadow[7:0]   <= bus.buf_data;
            endcase
          end
          if (last_beat) begin
            state        <= ENUM_FETCH_DONE;
            shadow_valid <= 1'b1;
          end else begin
            beat         <= beat + 2'd1;
            bus.buf_addr <= bus.buf_addr + BUFFER_BITS'(1);
            state        <= ENUM_FETCH_REQ;
          end
        end
        default: state <= ENUM_FETCH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/anton_neopixel_pixel_serializer.sv
// Loads prefetched pixels into the active register and shapes each bit's
// high time on the NeoPixel line; flags underruns.
module anton_neopixel_pixel_serializer
  import anton_neopixel_pixel_serializer_pkg::*;
#(
  parameter int BUFFER_END  = BUFFER_END_DEFAULT,
  parameter int T0H_STEPS   = T0H_STEPS_DEFAULT,
  parameter int T1H_STEPS   = T1H_STEPS_DEFAULT,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   rstn,
  input  logic                   stream_output,
  input  logic                   stream_reset,
  input  logic                   stream_bit_of,
  input  logic [2:0]             bit_pattern_index,
  input  logic [4:0]             pixel_bit_index,
  input  logic [BUFFER_BITS-1:0] pixel_index,
  input  logic [BUFFER_BITS-1:0] pixel_index_max,
  input  logic                   reg_ctrl_32bit,
  input  logic                   underrun_clr,
  anton_neopixel_pixel_serializer_if.master bus,
  output logic                   neo_data,
  output logic                   underrun
);

  logic [23:0] shadow;
  logic        shadow_valid;
  logic [23:0] active;
  logic [23:0] load_pixel;
  logic [23:0] src;
  logic        output_q;
  logic        start;
  logic        load;
  logic        bit_value;
  logic [3:0]  high_steps;

  anton_neopixel_pixel_fetch #(.BUFFER_BITS(BUFFER_BITS)) u_fetch (
    .clk7mhz         (clk7mhz),
    .rstn            (rstn),
    .stream_output   (stream_output),
    .stream_reset    (stream_reset),
    .pixel_index     (pixel_index),
    .pixel_index_max (pixel_index_max),
    .reg_ctrl_32bit  (reg_ctrl_32bit),
    .consume         (load),
    .bus             (bus),
    .shadow          (shadow),
    .shadow_valid    (shadow_valid)
  );

  assign start      = stream_output && !output_q;
  assign load       = start || stream_bit_of;
  assign load_pixel = shadow_valid ? shadow : 24'd0;
  // On the start cycle the active register is not loaded yet, so bypass it.
  assign src        = start ? load_pixel : active;
  assign bit_value  = src[5'd23 - pixel_bit_index];
  assign high_steps = bit_value ? 4'(T1H_STEPS) : 4'(T0H_STEPS);

  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      output_q <= 1'b0;
      active   <= '0;
      underrun <= 1'b0;
      neo_data <= 1'b0;
    end else begin
      output_q <= stream_output;
      if (load) active <= load_pixel;
      if (load && !shadow_valid) underrun <= 1'b1;
      else if (underrun_clr)     underrun <= 1'b0;
      neo_data <= stream_output && ({1'b0, bit_pattern_index} < high_steps);
    end
  end

endmodule

// File: tb/tb_anton_neopixel_pixel_serializer.sv
// Directed bench: emulates stream logic and the pixel buffer, predicts the
// NeoPixel waveform from buffer contents and checks it every cycle.
module tb_anton_neopixel_pixel_serializer;

  logic       clk7mhz = 1'b0;
  logic       rstn;
  logic       so, sr, bo, m32, uclr;
  logic [2:0] bpi;
  logic [4:0] pbi;
  logic [7:0] pidx, pmax;
  logic       neo, und;

  anton_neopixel_pixel_serializer_if #(.ADDR_BITS(8)) bus ();

  anton_neopixel_pixel_serializer dut (
    .clk7mhz           (clk7mhz),
    .rstn              (rstn),
    .stream_output     (so),
    .stream_reset      (sr),
    .stream_bit_of     (bo),
    .bit_pattern_index (bpi),
    .pixel_bit_index   (pbi),
    .pixel_index       (pidx),
    .pixel_index_max   (pmax),
    .reg_ctrl_32bit    (m32),
    .underrun_clr      (uclr),
    .bus               (bus),
    .neo_data          (neo),
    .underrun          (und)
  );

  always #5 clk7mhz = ~clk7mhz;

  logic [7:0]  mem [0:255];
  logic [7:0]  reads [$];
  int          total = 0;
  int          bad = 0;
  logic        exp_next = 1'b0;
  logic        exp_line = 1'b0;
  logic        checking = 1'b0;
  logic [23:0] exp_pixel;
  int          stall = 0;
  int          stall_at = -1;
  int          black_pix = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] model_expand(input logic [7:0] v);
    int r, g, b;
    r = int'(v) >> 5;
    g = (int'(v) >> 2) & 7;
    b = int'(v) & 3;
    return 24'((((g << 5) | (g << 2) | (g >> 1)) << 16) |
               (((r << 5) | (r << 2) | (r >> 1)) << 8) | (b * 85));
  endfunction

  function automatic logic [23:0] model_pixel(input int addr);
    int base;
    if (!m32) return model_expand(mem[addr]);
    base = addr - (addr % 4);
    return {mem[base], mem[base + 1], mem[base + 2]};
  endfunction

  function automatic logic [7:0] model_next(input int idx);
    int key;
    key = m32 ? (idx | 3) : idx;
    if (key == int'(pmax)) return 8'd0;
    return 8'((idx + (m32 ? 4 : 1)) % 256);
  endfunction

  // Buffer model: a granted beat returns its byte on the following cycle.
  initial begin
    logic       r;
    logic [7:0] a;
    forever begin
      @(posedge clk7mhz);
      r = bus.buf_req && bus.buf_gnt;
      a = bus.buf_addr;
      #1;
      bus.buf_data = r ? mem[a] : 8'h00;
      if (r) reads.push_back(a);
    end
  end

  always @(negedge clk7mhz)
    if (checking) check("neo_data", 32'(neo), 32'(exp_line));

  task automatic tick();
    @(posedge clk7mhz);
    #1;
    exp_line = exp_next;
    if (stall > 0) stall--;
    bus.buf_gnt = (stall == 0);
  endtask

  task automatic do_reset_phase(input int n);
    so = 1'b0; sr = 1'b1; bo = 1'b0; bpi = 3'd0; pbi = 5'd0; exp_next = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_stop(input int n);
    so = 1'b0; sr = 1'b0; bo = 1'b0; exp_next = 1'b0;
    repeat (n) tick();
  endtask

  task automatic run_output(input int ncycles);
    int pb;
    so = 1'b1; sr = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      if (c % 192 == 0) begin
        if (c > 0) pidx = model_next(int'(pidx));
        exp_pixel = ((c / 192) == black_pix) ? 24'd0 : model_pixel(int'(pidx));
      end
      bpi = 3'(c % 8);
      pb  = (c / 8) % 24;
      pbi = 5'(pb);
      bo  = (c % 192 == 191);
      if (c == stall_at) stall = 250;
      exp_next = (int'(bpi) < (exp_pixel[23 - pb] ? 5 : 2));
      tick();
    end
    if (ncycles % 192 == 0) pidx = model_next(int'(pidx));
    so = 1'b0; sr = 1'b0; bo = 1'b0; exp_next = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n3;
    rstn = 1'b1;
    so = 1'b0; sr = 1'b0; bo = 1'b0; m32 = 1'b0; uclr = 1'b0;
    bpi = 3'd0; pbi = 5'd0; pidx = 8'd0; pmax = 8'd0;
    bus.buf_gnt = 1'b1; bus.buf_data = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) % 256);
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk7mhz);
    #1;
    check("reset_neo_data", 32'(neo), 32'd0);
    check("reset_buf_req", 32'(bus.buf_req), 32'd0);
    check("reset_buf_addr", 32'(bus.buf_addr), 32'd0);
    check("reset_underrun", 32'(und), 32'd0);
    rstn = 1'b1;
    checking = 1'b1;

    // Hand-computed pins on the model.
    mem[0] = 8'hE0;
    mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56; mem[7] = 8'h78;
    m32 = 1'b0;
    check("model_rgb332_e0", 32'(model_pixel(0)), 32'h00FF00);
    check("model_rgb332_1c", 32'(model_expand(8'h1C)), 32'hFF0000);
    check("model_rgb332_03", 32'(model_expand(8'h03)), 32'h0000FF);
    pmax = 8'd2;
    check("model_next_8bit_wrap", 32'(model_next(2)), 32'd0);
    check("model_next_8bit_inc", 32'(model_next(1)), 32'd2);
    m32 = 1'b1; pmax = 8'd7;
    check("model_pixel_32bit", 32'(model_pixel(4)), 32'h123456);
    check("model_next_32bit_wrap", 32'(model_next(4)), 32'd0);

    // 8-bit, single pixel frame repeating 0xE0.
    m32 = 1'b0; pmax = 8'd0; pidx = 8'd0;
    do_reset_phase(20);
    run_output(384);
    do_stop(4);
    check("underrun_after_8bit", 32'(und), 32'd0);

    // 32-bit word at address 4.
    m32 = 1'b1; pmax = 8'd7; pidx = 8'd4;
    reads.delete();
    do_reset_phase(20);
    check("reads_32bit_count", 32'(reads.size()), 32'd3);
    if (reads.size() >= 3) begin
      check("read_addr_0", 32'(reads[0]), 32'd4);
      check("read_addr_1", 32'(reads[1]), 32'd5);
      check("read_addr_2", 32'(reads[2]), 32'd6);
    end
    run_output(384);
    do_stop(4);
    n3 = 0;
    foreach (reads[i]) if (reads[i][1:0] == 2'b11) n3++;
    check("no_byte3_reads", 32'(n3), 32'd0);

    // Wrap-around at pixel_index_max = 2, then resend pixel 0 after stream_reset.
    m32 = 1'b0; pmax = 8'd2; pidx = 8'd0;
    mem[0] = 8'h1C; mem[1] = 8'h03; mem[2] = 8'hA6; mem[3] = 8'h5A;
    reads.delete();
    do_reset_phase(20);
    run_output(576);
    check("wrap_reads_count", 32'(reads.size()), 32'd4);
    if (reads.size() >= 4) check("wrap_fetch_addr", 32'(reads[3]), 32'd0);
    do_reset_phase(20);
    run_output(192);
    do_stop(4);

    // Grant stall longer than a pixel.
    pmax = 8'd3; pidx = 8'd0;
    check("underrun_before_stall", 32'(und), 32'd0);
    stall_at = 191; black_pix = 2;
    do_reset_phase(20);
    run_output(768);
    stall_at = -1; black_pix = -1;
    check("underrun_after_stall", 32'(und), 32'd1);
    uclr = 1'b1;
    tick();
    uclr = 1'b0;
    check("underrun_cleared", 32'(und), 32'd0);
    do_stop(4);

    // Stop in the middle of a stalled fetch.
    pidx = 8'd0;
    stall = 1000;
    do_reset_phase(5);
    check("req_during_stall", 32'(bus.buf_req), 32'd1);
    so = 1'b0; sr = 1'b0;
    tick();
    check("req_after_stop", 32'(bus.buf_req), 32'd0);
    stall = 0;
    do_reset_phase(20);
    do_stop(1);
    black_pix = 0;
    run_output(192);
    black_pix = -1;
    check("underrun_after_stop_start", 32'(und), 32'd1);
    uclr = 1'b1;
    tick();
    uclr = 1'b0;
    do_stop(4);

    // Asynchronous reset in the middle of a high bit.
    m32 = 1'b0; pmax = 8'd0; pidx = 8'd0; mem[0] = 8'hE0;
    do_reset_phase(20);
    run_output(67);
    check("neo_high_mid_bit", 32'(neo), 32'd1);
    checking = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("neo_async_reset", 32'(neo), 32'd0);
    check("req_async_reset", 32'(bus.buf_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
